// File: rtl/interp_pkg.sv
// Shared types and constants for the 1:2 linear-interpolating upsampler.
package interp_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MID   = 2'd1,
    SAMP  = 2'd2
  } state_t;

endpackage

// File: rtl/interp_avg.sv
// Combinational mean of two unsigned samples, floor rounding by default.
// Defining INTERP_ROUND_EN switches to round-half-up.
module interp_avg
  import interp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] mean
);

  // The extra carry bit keeps the sum from wrapping before the halving shift.
  logic [WIDTH:0] sum;

`ifdef INTERP_ROUND_EN
  assign sum = {1'b0, x0} + {1'b0, x1} + {{WIDTH{1'b0}}, 1'b1};
`else
  assign sum = {1'b0, x0} + {1'b0, x1};
`endif

  assign mean = WIDTH'(sum >> 1);

endmodule

// File: rtl/interp.sv
// 1:2 linear-interpolating upsampler: each accepted sample x[n] yields the
// midpoint with x[n-1] followed by x[n]. Optional macro: INTERP_ROUND_EN.
module interp
  import interp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] a,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] mid;
  logic             accept;

  interp_avg #(.WIDTH(WIDTH)) u_avg (
    .x0   (prev),
    .x1   (cur),
    .mean (mid)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      prev <= '0;
      cur  <= '0;
    end else if (accept) begin
      prev <= cur;
      cur  <= a;
    end
  end

  // Samples only move on accept, which never happens while an output stalls.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out        = '0;
    case (state)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = MID;
        end
      end
      MID: begin
        out_valid = 1'b1;
        out       = mid;
        if (out_ready) begin
          state_next = SAMP;
        end
      end
      SAMP: begin
        out_valid = 1'b1;
        out       = cur;
        in_ready  = out_ready;
        if (out_ready) begin
          state_next = in_valid ? MID : EMPTY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

endmodule

// File: tb/tb_interp.sv
// Self-checking bench for interp: directed scenarios plus a randomized run
// scored against a queue-based reference of the interpolated stream.
module tb_interp;

  localparam int W = 8;

  logic         CLK;
  logic         RSTN;
  logic [W-1:0] a;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int obs_q[$];
  int exp_list[$];
  int model_prev = 0;
  int n_in = 0;
  int n_out = 0;
  int ticks = 0;

  interp #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .a         (a),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int refMid(input int p, input int x);
`ifdef INTERP_ROUND_EN
    return (p + x + 1) / 2;
`else
    return (p + x) / 2;
`endif
  endfunction

  // One clock cycle: score the handshakes visible now, then advance to the next negedge.
  task automatic tick(output bit accepted);
    #1;
    checkOutput("out_valid", int'(out_valid), int'(exp_q.size() != 0));
    checkOutput("in_ready", int'(in_ready),
                int'(exp_q.size() == 0 || (exp_q.size() == 1 && out_ready)));
    if (!out_valid) checkOutput("out_idle", int'(out), 0);
    if (out_valid && out_ready) begin
      obs_q.push_back(int'(out));
      n_out++;
      if (exp_q.size() == 0) checkOutput("extra_out", 1, 0);
      else checkOutput("stream", int'(out), exp_q.pop_front());
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      exp_q.push_back(refMid(model_prev, int'(a)));
      exp_q.push_back(int'(a));
      model_prev = int'(a);
      n_in++;
    end
    ticks++;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input int value);
    bit acc;
    int budget;
    a = W'(value);
    in_valid = 1'b1;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 20) begin
      tick(acc);
      budget++;
    end
    if (!acc) checkOutput("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int budget;
    out_ready = 1'b1;
    in_valid = 1'b0;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      tick(acc);
      budget++;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic compareObserved(input string tag);
    checkOutput({tag, "_count"}, obs_q.size(), exp_list.size());
    for (int i = 0; i < exp_list.size() && i < obs_q.size(); i++) begin
      checkOutput(tag, obs_q[i], exp_list[i]);
    end
    obs_q.delete();
  endtask

  // Reset asserted away from any clock edge so its asynchronous effect is visible.
  task automatic doReset();
    #2;
    RSTN = 1'b0;
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out", int'(out), 0);
    exp_q.delete();
    obs_q.delete();
    model_prev = 0;
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    bit acc;
    int t0;
    int cycles;
    int rin;
    int rout;
    RSTN = 1'b0;
    a = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out", int'(out), 0);
    RSTN = 1'b1;
    @(negedge CLK);
    checkOutput("reset_in_ready", int'(in_ready), 1);

    // Basic stream 4, 8, 2.
    applyStimulus(4);
    applyStimulus(8);
    applyStimulus(2);
    drain();
    exp_list = '{2, 4, 6, 8, 5, 2};
    compareObserved("seq_482");

    // Full-scale inputs exercise the carry bit of the average.
    doReset();
    applyStimulus(255);
    applyStimulus(255);
    drain();
`ifdef INTERP_ROUND_EN
    exp_list = '{128, 255, 255, 255};
`else
    exp_list = '{127, 255, 255, 255};
`endif
    compareObserved("seq_max");

    // Back-pressure holds MID steady.
    doReset();
    out_ready = 1'b0;
    applyStimulus(10);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_out", int'(out), 5);
      checkOutput("stall_valid", int'(out_valid), 1);
      checkOutput("stall_in_ready", int'(in_ready), 0);
      tick(acc);
    end
    drain();
    exp_list = '{5, 10};
    compareObserved("seq_stall");

    // in_valid held high: two outputs per input with no bubble.
    doReset();
    a = 8'd3;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++) tick(acc);
    t0 = ticks;
    a = 8'd6;
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++) tick(acc);
    drain();
    checkOutput("burst_cycles", ticks - t0, 4);
    exp_list = '{1, 3, 4, 6};
    compareObserved("seq_burst");

    // Reset while MID is presented discards it; next input averages with 0.
    doReset();
    out_ready = 1'b0;
    applyStimulus(100);
    checkOutput("pre_rst_mid", int'(out), 50);
    checkOutput("pre_rst_valid", int'(out_valid), 1);
    doReset();
    out_ready = 1'b1;
    applyStimulus(20);
    drain();
    exp_list = '{10, 20};
    compareObserved("seq_rst");

    // Randomized valid/ready traffic.
    doReset();
    n_in = 0;
    n_out = 0;
    cycles = 0;
    while (n_in < 1000 && cycles < 20000) begin
      in_valid = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      a = W'($urandom);
      tick(acc);
      obs_q.delete();
      cycles++;
    end
    if (n_in < 1000) checkOutput("rand_budget", n_in, 1000);
    drain();
    obs_q.delete();
    rin = n_in;
    rout = n_out;
    checkOutput("rand_out_count", rout, 2 * rin);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
